fmac2fib_rxctrl: RTL and testbench

Receive-side control between the FMAC RX FIFO and the fabric-side read FIFOs, running in the `clk_fib` domain. It pops one header qword per packet from the FMAC RX FIFO, checks space in the read data FIFO, and moves the packet's data qwords into that FIFO. It then writes one byte-count/status word into the read-count FIFO. A count-FIFO entry therefore always means the matching data is complete in the data FIFO.

---
 rtl/fmac2fib_rxctrl_if.sv | 25 ++
 rtl/fmac2fib_rxctrl.sv | 119 +++++++++++
 tb/tb_fmac2fib_rxctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmac2fib_rxctrl_if.sv
// FMAC RX FIFO / fabric read FIFO handshake bundle for fmac2fib_rxctrl.
// master = the receive controller, slave = the FIFO side.
interface fmac2fib_rxctrl_if #(
    parameter int unsigned RF_AW = 13
);
    logic             mac_fib_rxempty;
    logic [63:0]      mac_fib_rxdata;
    logic             fib_mac_rxrd;
    logic [RF_AW-1:0] wrusedw_rf;
    logic             wrfull_rcf;
    logic             wrreq_rf;
    logic [63:0]      datain_rf;
    logic             wrreq_rcf;
    logic [31:0]      datain_rcf;

    modport master (
        input  mac_fib_rxempty, mac_fib_rxdata, wrusedw_rf, wrfull_rcf,
        output fib_mac_rxrd, wrreq_rf, datain_rf, wrreq_rcf, datain_rcf
    );

    modport slave (
        output mac_fib_rxempty, mac_fib_rxdata, wrusedw_rf, wrfull_rcf,
        input  fib_mac_rxrd, wrreq_rf, datain_rf, wrreq_rcf, datain_rcf
    );
endinterface

// File: rtl/fmac2fib_rxctrl.sv
// Receive control: pops one header + qw data qwords per packet from the FMAC
// RX FIFO into the read data FIFO, then posts {bcnt, status} to the count FIFO.
// Optional macro RX_DROP_BAD_EN: error packets (status[0]) are drained and dropped.
module fmac2fib_rxctrl #(
    parameter int unsigned RF_AW = 13
) (
    input  logic              clk_fib,
    input  logic              reset,
    fmac2fib_rxctrl_if.master bus,
    output logic              test
);
    localparam int unsigned QW_W = 14;
    localparam int unsigned CW   = (RF_AW + 1 > QW_W) ? RF_AW + 1 : QW_W;
    localparam logic [CW-1:0] RF_MAX = CW'((64'd1 << RF_AW) - 64'd1);

    localparam logic [5:0] RD_IDLE  = 6'b000001;
    localparam logic [5:0] RD_HDR   = 6'b000010;
    localparam logic [5:0] RD_HWAIT = 6'b000100;
    localparam logic [5:0] RD_CHK   = 6'b001000;
    localparam logic [5:0] RD_DATA  = 6'b010000;
    localparam logic [5:0] RD_DONE  = 6'b100000;

    logic [5:0]      state;
    logic [5:0]      state_nxt;
    logic [15:0]     bcnt;
    logic [15:0]     status;
    logic [QW_W-1:0] qw;
    logic [QW_W-1:0] qw_hdr;
    logic [QW_W-1:0] remain;
    logic            rxrd;
    logic            rd_data_d1;
    logic            drop_cur;
    logic            space_ok;

    assign test              = 1'b0;
    assign bus.fib_mac_rxrd  = rxrd;
    assign qw_hdr            = QW_W'((17'(bus.mac_fib_rxdata[15:0]) + 17'd7) >> 3);
    assign space_ok          = (RF_MAX - CW'(bus.wrusedw_rf)) > CW'(qw);

`ifdef RX_DROP_BAD_EN
    assign drop_cur = status[0];
`else
    assign drop_cur = 1'b0;
`endif

    // Next-state and FMAC read enable
    always_comb begin
        state_nxt = state;
        rxrd      = 1'b0;
        case (state)
            RD_IDLE: begin
                if (!bus.mac_fib_rxempty && !bus.wrfull_rcf) state_nxt = RD_HDR;
            end
            RD_HDR: begin
                rxrd = !bus.mac_fib_rxempty;
                if (!bus.mac_fib_rxempty) state_nxt = RD_HWAIT;
            end
            RD_HWAIT: state_nxt = RD_CHK;
            RD_CHK: begin
                if (qw == '0)                 state_nxt = RD_DONE;
                else if (drop_cur || space_ok) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rxrd = !bus.mac_fib_rxempty && (remain != '0);
                if (remain == '0) state_nxt = RD_DONE;
            end
            RD_DONE: state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_fib) begin
        if (reset) state <= RD_IDLE;
        else       state <= state_nxt;
    end

    // Header latch and remaining-qword counter
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            bcnt   <= '0;
            status <= '0;
            qw     <= '0;
            remain <= '0;
        end else begin
            if (state == RD_HWAIT) begin
                bcnt   <= bus.mac_fib_rxdata[15:0];
                status <= bus.mac_fib_rxdata[31:16];
                qw     <= qw_hdr;
            end
            if (state == RD_CHK && state_nxt == RD_DATA) remain <= qw;
            else if (state == RD_DATA && rxrd)            remain <= remain - QW_W'(1);
        end
    end

    // Data path: data read at t is written to the data FIFO at t+2
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            rd_data_d1    <= 1'b0;
            bus.wrreq_rf  <= 1'b0;
            bus.datain_rf <= '0;
        end else begin
            rd_data_d1   <= rxrd && (state == RD_DATA);
            bus.wrreq_rf <= rd_data_d1 && !drop_cur;
            if (rd_data_d1 && !drop_cur) bus.datain_rf <= bus.mac_fib_rxdata;
        end
    end

    // Count word, posted one cycle after RD_DONE
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            bus.wrreq_rcf  <= 1'b0;
            bus.datain_rcf <= '0;
        end else begin
            bus.wrreq_rcf <= (state == RD_DONE) && !drop_cur;
            if (state == RD_DONE && !drop_cur) bus.datain_rcf <= {bcnt, status};
        end
    end
endmodule

// File: tb/tb_fmac2fib_rxctrl.sv
// Self-checking bench for fmac2fib_rxctrl: FMAC FIFO model, packet-level
// expectation queues, and directed scenarios with literal expectations.
module tb_fmac2fib_rxctrl;
    localparam int unsigned RF_AW = 13;

    logic clk_fib;
    logic reset;
    logic test;

    fmac2fib_rxctrl_if #(.RF_AW(RF_AW)) bus ();

    fmac2fib_rxctrl #(.RF_AW(RF_AW)) dut (
        .clk_fib (clk_fib),
        .reset   (reset),
        .bus     (bus),
        .test    (test)
    );

    initial clk_fib = 1'b0;
    always #5 clk_fib = ~clk_fib;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // FMAC RX FIFO model
    logic [63:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          stall  = 1'b0;
    int          pkt_id = 0;

    assign bus.mac_fib_rxempty = (rd_ptr == wr_ptr) || stall;

    always @(posedge clk_fib) begin
        if (reset) begin
            rd_ptr             <= wr_ptr;
            bus.mac_fib_rxdata <= '0;
        end else if (bus.fib_mac_rxrd) begin
            chk("fmac_underflow", 64'(bus.mac_fib_rxempty), 64'd0);
            bus.mac_fib_rxdata <= mem[rd_ptr % 4096];
            rd_ptr             <= rd_ptr + 1;
        end
    end

    // Expected output model
    logic [63:0] exp_data [$];
    logic [31:0] exp_cnt  [$];
    int          exp_left [$];
    bit          exp_had  [$];

    task automatic push_pkt(input logic [15:0] bcnt, input logic [15:0] status);
        int  qw;
        bit  dropped;
        logic [63:0] w;
        qw = (int'(bcnt) + 7) / 8;
        dropped = 1'b0;
`ifdef RX_DROP_BAD_EN
        dropped = status[0];
`endif
        pkt_id++;
        mem[wr_ptr % 4096] = {32'hDEAD_BEEF, status, bcnt};
        for (int i = 0; i < qw; i++) begin
            w = {16'hA5C3, 16'(pkt_id), 32'(i) * 32'h9E37_79B1};
            mem[(wr_ptr + 1 + i) % 4096] = w;
            if (!dropped) exp_data.push_back(w);
        end
        if (!dropped) begin
            exp_cnt.push_back({bcnt, status});
            exp_left.push_back(qw);
            exp_had.push_back(qw != 0);
        end
        wr_ptr = wr_ptr + 1 + qw;
    endtask

    // Observation counters
    int          cyc = 0;
    int          n_data = 0;
    int          n_cnt = 0;
    int          last_data_cyc = 0;
    int          first_data_cyc = -1;
    logic [31:0] last_cnt = '0;
    logic [31:0] first_cnt = '0;
    bit          first_cnt_seen = 1'b0;

    // Per-cycle compare against the model
    initial forever begin
        @(posedge clk_fib);
        #1;
        cyc++;
        chk("test_tied0", 64'(test), 64'd0);
        if (bus.wrreq_rf) begin
            n_data++;
            if (first_data_cyc < 0) first_data_cyc = cyc;
            last_data_cyc = cyc;
            if (exp_data.size() == 0) begin
                chk("spurious_data_write", bus.datain_rf, 64'd0);
                if (bus.datain_rf == 64'd0) chk("spurious_data_write", 64'd1, 64'd0);
            end else begin
                chk("data_word", bus.datain_rf, exp_data.pop_front());
                for (int i = 0; i < exp_left.size(); i++) begin
                    if (exp_left[i] > 0) begin
                        exp_left[i] = exp_left[i] - 1;
                        break;
                    end
                end
            end
        end
        if (bus.wrreq_rcf) begin
            n_cnt++;
            last_cnt = bus.datain_rcf;
            if (!first_cnt_seen) begin
                first_cnt      = bus.datain_rcf;
                first_cnt_seen = 1'b1;
            end
            if (exp_cnt.size() == 0) begin
                chk("spurious_count_write", 64'(bus.wrreq_rcf), 64'd0);
            end else begin
                chk("count_word", 64'(bus.datain_rcf), 64'(exp_cnt.pop_front()));
                chk("count_after_data", 64'(exp_left.pop_front()), 64'd0);
                if (exp_had.pop_front())
                    chk("count_latency", 64'(cyc - last_data_cyc), 64'd1);
            end
        end
    end

    int m_data;
    int m_cnt;

    task automatic mark();
        m_data         = n_data;
        m_cnt          = n_cnt;
        first_data_cyc = -1;
        first_cnt_seen = 1'b0;
    endtask

    task automatic drain(input bit tog);
        int n;
        n = 0;
        while (!(exp_cnt.size() == 0 && rd_ptr == wr_ptr) && n < 2000) begin
            @(negedge clk_fib);
            if (tog) stall = ~stall;
            n++;
        end
        stall = 1'b0;
        chk("drain_timeout", 64'(n < 2000), 64'd1);
        repeat (8) @(negedge clk_fib);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rxrd"},       64'(bus.fib_mac_rxrd), 64'd0);
        chk({tag, "_wrreq_rf"},   64'(bus.wrreq_rf),     64'd0);
        chk({tag, "_datain_rf"},  bus.datain_rf,         64'd0);
        chk({tag, "_wrreq_rcf"},  64'(bus.wrreq_rcf),    64'd0);
        chk({tag, "_datain_rcf"}, 64'(bus.datain_rcf),   64'd0);
        chk({tag, "_test"},       64'(test),             64'd0);
    endtask

    initial begin
        int n;
        int hdr_ptr;
        reset          = 1'b1;
        bus.wrusedw_rf = '0;
        bus.wrfull_rcf = 1'b0;
        repeat (3) @(posedge clk_fib);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk_fib);
        reset = 1'b0;

        // bcnt=64: 8 back-to-back writes then one count word
        mark();
        push_pkt(16'd64, 16'h0000);
        drain(1'b0);
        chk("b64_data_writes", 64'(n_data - m_data), 64'd8);
        chk("b64_cnt_writes", 64'(n_cnt - m_cnt), 64'd1);
        chk("b64_count_word", 64'(last_cnt), 64'h0040_0000);
        chk("b64_back_to_back", 64'(last_data_cyc - first_data_cyc), 64'd7);

        // bcnt=13: rounds up to 2 qwords
        mark();
        push_pkt(16'd13, 16'h0000);
        drain(1'b0);
        chk("b13_data_writes", 64'(n_data - m_data), 64'd2);
        chk("b13_bcnt_field", 64'(last_cnt[31:16]), 64'h000D);

        // bcnt=0: count write only
        mark();
        push_pkt(16'd0, 16'h0000);
        drain(1'b0);
        chk("b0_data_writes", 64'(n_data - m_data), 64'd0);
        chk("b0_cnt_writes", 64'(n_cnt - m_cnt), 64'd1);
        chk("b0_count_word", 64'(last_cnt), 64'h0);

        // Count FIFO full blocks the header read
        @(negedge clk_fib);
        bus.wrfull_rcf = 1'b1;
        mark();
        hdr_ptr = rd_ptr;
        push_pkt(16'd8, 16'h0000);
        repeat (10) @(negedge clk_fib);
        chk("rcf_full_no_hdr_read", 64'(rd_ptr - hdr_ptr), 64'd0);
        bus.wrfull_rcf = 1'b0;
        drain(1'b0);
        chk("rcf_full_then_writes", 64'(n_data - m_data), 64'd1);

        // Space check boundary: 7 and 8 free are not enough for qw=8, 9 is
        bus.wrusedw_rf = 13'h1FF8;
        mark();
        hdr_ptr = rd_ptr;
        push_pkt(16'd64, 16'h0000);
        repeat (20) @(negedge clk_fib);
        chk("space_hold_reads", 64'(rd_ptr - hdr_ptr), 64'd1);
        chk("space_hold_rxrd", 64'(bus.fib_mac_rxrd), 64'd0);
        bus.wrusedw_rf = 13'h1FF7;
        repeat (10) @(negedge clk_fib);
        chk("space_eq_hold_reads", 64'(rd_ptr - hdr_ptr), 64'd1);
        chk("space_hold_writes", 64'(n_data - m_data), 64'd0);
        bus.wrusedw_rf = 13'h1FF6;
        drain(1'b0);
        chk("space_release_writes", 64'(n_data - m_data), 64'd8);
        bus.wrusedw_rf = '0;

        // FMAC empty toggling: no bubbles or duplicates
        mark();
        push_pkt(16'd40, 16'h0000);
        drain(1'b1);
        chk("stall_data_writes", 64'(n_data - m_data), 64'd5);
        chk("stall_cnt_writes", 64'(n_cnt - m_cnt), 64'd1);

        // Error packet followed by a good one
        mark();
        push_pkt(16'd24, 16'h0001);
        push_pkt(16'd8, 16'h0000);
        drain(1'b0);
`ifdef RX_DROP_BAD_EN
        chk("err_data_writes", 64'(n_data - m_data), 64'd1);
        chk("err_cnt_writes", 64'(n_cnt - m_cnt), 64'd1);
        chk("err_first_count", 64'(first_cnt), 64'h0008_0000);
`else
        chk("err_data_writes", 64'(n_data - m_data), 64'd4);
        chk("err_cnt_writes", 64'(n_cnt - m_cnt), 64'd2);
        chk("err_first_count", 64'(first_cnt), 64'h0018_0001);
`endif
        chk("err_fmac_drained", 64'(rd_ptr), 64'(wr_ptr));

        // Reset in the middle of RD_DATA
        mark();
        push_pkt(16'd64, 16'h0000);
        n = 0;
        while (n_data - m_data < 3 && n < 200) begin
            @(negedge clk_fib);
            n++;
        end
        chk("mid_rst_reached_data", 64'(n < 200), 64'd1);
        reset = 1'b1;
        exp_data.delete();
        exp_cnt.delete();
        exp_left.delete();
        exp_had.delete();
        @(posedge clk_fib);
        #1;
        chk_outputs_zero("mid_rst");
        @(negedge clk_fib);
        reset = 1'b0;
        repeat (4) @(negedge clk_fib);
        chk("mid_rst_no_writes", 64'(n_data - m_data), 64'd3);

        // Recovery after reset
        mark();
        push_pkt(16'd8, 16'h0000);
        drain(1'b0);
        chk("post_rst_data_writes", 64'(n_data - m_data), 64'd1);
        chk("post_rst_count_word", 64'(last_cnt), 64'h0008_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
